ahb2apb_bridge: RTL and testbench
=================================

# ahb2apb_bridge

AHB-to-APB bridge. It accepts AHB-Lite single and burst transfers from an AHB master in the address range 0x8000_0000–0x8BFF_FFFF. It converts each transfer into a two-phase APB transfer (SETUP then ENABLE) to one of three APB slaves, stalling the AHB side through `Hreadyout` as needed. It sits between the system AHB master and the peripheral APB segment.

## Interface
- No parameters. Address map, state encoding and widths are fixed.
- `Hclk` in 1: single clock; all state changes on rising edge.
- `Hresetn` in 1: reset, asynchronous, active-low.
- `Hwrite` in 1: AHB direction (1 = write).
- `Hreadyin` in 1: AHB ready from bus; a transfer is accepted only when high.
- `Hwdata` in 32: AHB write data (data phase, one cycle after address).
- `Haddr` in 32: AHB address (address phase).
- `Htrans` in 2: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- `Prdata` in 32: APB read data.
- `Penable` out 1: APB enable.
- `Pwrite` out 1: APB direction.
- `Pselx` out 3: one-hot APB slave select.
- `Paddr` out 32: APB address.
- `Pwdata` out 32: APB write data.
- `Hreadyout` out 1: bridge ready to AHB master (0 = wait).
- `Hresp` out 2: always 00 (OKAY).
- `Hrdata` out 32: read data to AHB, equal to `Prdata` combinationally.

## Operation
- `valid` = `Hreadyin` & `Htrans`∈{10,11} & 0x8000_0000 ≤ `Haddr` < 0x8C00_0000.
- Slave decode (`tempselx`):
  - 0x8000_0000–0x83FF_FFFF → 001.
  - 0x8400_0000–0x87FF_FFFF → 010.
  - 0x8800_0000–0x8BFF_FFFF → 100.
  - Any other address → 000.
- Pipeline registers, updated every clock:
  - Address: `Haddr1`←`Haddr`, `Haddr2`←`Haddr1`.
  - Data: `Hwdata1`←`Hwdata`, `Hwdata2`←`Hwdata1`.
  - Direction: `Hwrite_reg`←`Hwrite`.
- Write transfers use `Haddr1`/`Hwdata` (or `Haddr2`/`Hwdata1` for the pipelined WRITEP path). Read transfers use the current `Haddr`.
- FSM states and transitions:
  - IDLE: !valid → IDLE; valid&Hwrite → WWAIT; valid&!Hwrite → READ.
  - WWAIT: !valid → WRITE; valid → WRITEP.
  - READ: → RENABLE.
  - WRITE: !valid → WENABLE; valid → WENABLEP.
  - WRITEP: → WENABLEP.
  - RENABLE and WENABLE: !valid → IDLE; valid&Hwrite → WWAIT; valid&!Hwrite → READ.
  - WENABLEP: !Hwrite_reg → READ; Hwrite_reg&valid → WRITEP; Hwrite_reg&!valid → WRITE.
- Outputs per state (registered, driven on the edge entering the state):
  - IDLE, WWAIT: `Pselx`=000, `Penable`=0, `Hreadyout`=1.
  - READ: `Pselx`=tempselx, `Paddr`=`Haddr`, `Pwrite`=0, `Penable`=0, `Hreadyout`=0.
  - WRITE/WRITEP (SETUP): `Pselx`=tempselx, `Pwrite`=1, `Penable`=0, `Hreadyout`=0; `Paddr`/`Pwdata` from the pipeline registers above.
  - RENABLE/WENABLE/WENABLEP (ENABLE): `Pselx`, `Paddr`, `Pwdata` and `Pwrite` hold; `Penable`=1, `Hreadyout`=1.
- APB slaves have no wait states: every APB transfer is exactly one SETUP cycle plus one ENABLE cycle.
- `Hresp` is tied to 00. Error responses are not generated.

## Timing
- Reset (async assert, takes effect without a clock edge):
  - State → IDLE.
  - `Pselx`=000, `Penable`=0, `Pwrite`=0, `Paddr`=0, `Pwdata`=0.
  - `Hreadyout`=1.
  - All pipeline registers = 0.
- Reset released: the first transfer may be accepted on the first rising edge after release.
- Single write (address phase at edge N, data at N+1):
  - WWAIT at N+1.
  - SETUP at N+2: `Pselx`/`Paddr`/`Pwdata`/`Pwrite`=1 valid.
  - ENABLE at N+3.
  - Back in IDLE at N+4.
- Single read (address accepted at edge N):
  - SETUP at N+1.
  - ENABLE at N+2. `Hrdata`=`Prdata` in this cycle, with `Hreadyout`=1.
- `Hreadyout` is low exactly during SETUP cycles. The master must hold address/control while `Hreadyout`=0.
- Write followed by back-to-back valid write: WRITEP/WENABLEP alternate, giving one APB transfer per two clocks with no IDLE between.
- Write followed by read: WENABLEP → READ directly.
- BUSY or IDLE `Htrans`, or `Hreadyin`=0, is treated as !valid.
- Reset asserted mid-transfer aborts it immediately: `Penable`/`Pselx` drop asynchronously and no completion is signalled.

## Test plan
- Reset: `Hresetn`=0 for 1 cycle → `Pselx`=000, `Penable`=0, `Hreadyout`=1, `Hresp`=00.
- Single write:
  - Stimulus: `Haddr`=0x8000_0000, `Htrans`=10, `Hwrite`=1, then `Hwdata`=0x0000_00A5.
  - Required: one SETUP cycle with `Pselx`=001, `Paddr`=0x8000_0000, `Pwdata`=0xA5, `Pwrite`=1, `Penable`=0, `Hreadyout`=0; then one ENABLE cycle with `Penable`=1, `Hreadyout`=1; then IDLE.
- Single read:
  - Stimulus: `Haddr`=0x8400_0010, `Hwrite`=0, `Prdata`=0x1234_5678.
  - Required: `Pselx`=010, `Pwrite`=0; in ENABLE, `Penable`=1 and `Hrdata`=0x1234_5678.
- Burst write of 4 beats (NONSEQ+3×SEQ, addresses 0x8800_0000 +4 per beat, data 1..4):
  - `Pselx`=100 throughout.
  - Four SETUP/ENABLE pairs, in order: `Paddr`=0x8800_0000/`Pwdata`=1, 0x8800_0004/2, 0x8800_0008/3, 0x8800_000C/4.
  - No IDLE between beats.
- Out-of-range or non-accepted transfer:
  - `Haddr`=0x7000_0000 with `Htrans`=10 → no `Pselx` activity.
  - `Htrans`=01 (BUSY) → no `Pselx` activity.
  - `Hreadyin`=0 → no `Pselx` activity.
- Reset mid-write: assert `Hresetn` low during SETUP → outputs return to reset values immediately; after release, a new transfer completes normally.

Source files
------------

// File: rtl/ahb2apb_bridge.sv
// ahb2apb_bridge: AHB-Lite to APB bridge for three zero-wait-state APB slaves at
// 0x8000_0000-0x8BFF_FFFF; every accepted AHB transfer becomes one APB SETUP+ENABLE pair.
`default_nettype none

module ahb2apb_bridge (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic        Hwrite,
  input  logic        Hreadyin,
  input  logic [31:0] Hwdata,
  input  logic [31:0] Haddr,
  input  logic [1:0]  Htrans,
  input  logic [31:0] Prdata,
  output logic        Penable,
  output logic        Pwrite,
  output logic [2:0]  Pselx,
  output logic [31:0] Paddr,
  output logic [31:0] Pwdata,
  output logic        Hreadyout,
  output logic [1:0]  Hresp,
  output logic [31:0] Hrdata
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WWAIT    = 3'd1,
    ST_READ     = 3'd2,
    ST_WRITE    = 3'd3,
    ST_WRITEP   = 3'd4,
    ST_RENABLE  = 3'd5,
    ST_WENABLE  = 3'd6,
    ST_WENABLEP = 3'd7
  } state_t;

  state_t      state_q;
  logic [31:0] haddr1_q, haddr2_q, hwdata1_q;
  logic        hwrite_reg_q;
  logic [2:0]  pselx_q;
  logic        penable_q, pwrite_q, hreadyout_q;
  logic [31:0] paddr_q, pwdata_q;

  logic        valid;
  logic [31:0] wr_addr, wr_data;

  // Each slave owns one 64 MB window, selected by Haddr[31:26].
  function automatic logic [2:0] decode(input logic [5:0] region);
    case (region)
      6'b100000: decode = 3'b001;
      6'b100001: decode = 3'b010;
      6'b100010: decode = 3'b100;
      default:   decode = 3'b000;
    endcase
  endfunction

  assign valid = Hreadyin && (Htrans inside {2'b10, 2'b11}) && (decode(Haddr[31:26]) != 3'b000);

  // Writes issued from WENABLEP belong to the beat one stage further back in the pipeline.
  assign wr_addr = (state_q == ST_WENABLEP) ? haddr2_q  : haddr1_q;
  assign wr_data = (state_q == ST_WENABLEP) ? hwdata1_q : Hwdata;

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q      <= ST_IDLE;
      haddr1_q     <= '0;
      haddr2_q     <= '0;
      hwdata1_q    <= '0;
      hwrite_reg_q <= 1'b0;
      pselx_q      <= 3'b000;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      hreadyout_q  <= 1'b1;
    end else begin
      haddr1_q     <= Haddr;
      haddr2_q     <= haddr1_q;
      hwdata1_q    <= Hwdata;
      hwrite_reg_q <= Hwrite;

      case (state_q)
        ST_IDLE, ST_RENABLE, ST_WENABLE: begin
          penable_q <= 1'b0;
          if (valid && Hwrite) begin
            state_q     <= ST_WWAIT;
            pselx_q     <= 3'b000;
            hreadyout_q <= 1'b1;
          end else if (valid) begin
            state_q     <= ST_READ;
            pselx_q     <= decode(Haddr[31:26]);
            paddr_q     <= Haddr;
            pwrite_q    <= 1'b0;
            hreadyout_q <= 1'b0;
          end else begin
            state_q     <= ST_IDLE;
            pselx_q     <= 3'b000;
            hreadyout_q <= 1'b1;
          end
        end

        ST_WWAIT: begin
          state_q     <= valid ? ST_WRITEP : ST_WRITE;
          pselx_q     <= decode(wr_addr[31:26]);
          paddr_q     <= wr_addr;
          pwdata_q    <= wr_data;
          pwrite_q    <= 1'b1;
          penable_q   <= 1'b0;
          hreadyout_q <= 1'b0;
        end

        ST_READ: begin
          state_q     <= ST_RENABLE;
          penable_q   <= 1'b1;
          hreadyout_q <= 1'b1;
        end

        ST_WRITE: begin
          state_q     <= valid ? ST_WENABLEP : ST_WENABLE;
          penable_q   <= 1'b1;
          hreadyout_q <= 1'b1;
        end

        ST_WRITEP: begin
          state_q     <= ST_WENABLEP;
          penable_q   <= 1'b1;
          hreadyout_q <= 1'b1;
        end

        ST_WENABLEP: begin
          penable_q   <= 1'b0;
          hreadyout_q <= 1'b0;
          if (!hwrite_reg_q) begin
            state_q  <= ST_READ;
            pselx_q  <= decode(Haddr[31:26]);
            paddr_q  <= Haddr;
            pwrite_q <= 1'b0;
          end else begin
            state_q  <= valid ? ST_WRITEP : ST_WRITE;
            pselx_q  <= decode(wr_addr[31:26]);
            paddr_q  <= wr_addr;
            pwdata_q <= wr_data;
            pwrite_q <= 1'b1;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Pselx     = pselx_q;
  assign Penable   = penable_q;
  assign Pwrite    = pwrite_q;
  assign Paddr     = paddr_q;
  assign Pwdata    = pwdata_q;
  assign Hreadyout = hreadyout_q;
  assign Hresp     = 2'b00;
  assign Hrdata    = Prdata;

endmodule

`default_nettype wire

// File: tb/tb_ahb2apb_bridge.sv
// tb_ahb2apb_bridge: cycle-vector table for the AHB side plus an APB transfer scoreboard.
`default_nettype none

module tb_ahb2apb_bridge;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;
  localparam logic [31:0] BA    = 32'h8800_0000;

  logic        Hclk = 1'b0;
  logic        Hresetn = 1'b0;
  logic        Hwrite = 1'b0;
  logic        Hreadyin = 1'b1;
  logic [31:0] Hwdata = '0;
  logic [31:0] Haddr = '0;
  logic [1:0]  Htrans = T_IDLE;
  logic [31:0] Prdata = '0;
  logic        Penable, Pwrite, Hreadyout;
  logic [2:0]  Pselx;
  logic [31:0] Paddr, Pwdata, Hrdata;
  logic [1:0]  Hresp;

  ahb2apb_bridge dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
    .Hwdata(Hwdata), .Haddr(Haddr), .Htrans(Htrans), .Prdata(Prdata),
    .Penable(Penable), .Pwrite(Pwrite), .Pselx(Pselx), .Paddr(Paddr),
    .Pwdata(Pwdata), .Hreadyout(Hreadyout), .Hresp(Hresp), .Hrdata(Hrdata)
  );

  always #5 Hclk = ~Hclk;

  typedef struct {
    logic        rdy;
    logic [1:0]  tr;
    logic        wr;
    logic [31:0] addr, wdata, prdata;
    logic [2:0]  e_sel;
    logic        e_en, e_rdy;
    logic        push;
    logic [2:0]  x_sel;
    logic [31:0] x_addr, x_data;
    logic        x_wr;
  } vec_t;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] addr, data;
    logic        wr;
  } xfer_t;

  vec_t  vecs[$];
  xfer_t sbq[$];
  int    checks = 0;
  int    errors = 0;
  int    rowno  = 0;

  function automatic vec_t row(input logic rdy, input logic [1:0] tr, input logic wr,
                               input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                               input logic [2:0] esel, input logic een, input logic erdy,
                               input logic push, input logic [2:0] xsel, input logic [31:0] xa,
                               input logic [31:0] xd, input logic xw);
    vec_t v;
    v.rdy = rdy; v.tr = tr; v.wr = wr; v.addr = a; v.wdata = wd; v.prdata = rd;
    v.e_sel = esel; v.e_en = een; v.e_rdy = erdy;
    v.push = push; v.x_sel = xsel; v.x_addr = xa; v.x_data = xd; v.x_wr = xw;
    return v;
  endfunction

  function automatic vec_t rw(input logic rdy, input logic [1:0] tr, input logic wr,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                              input logic [2:0] esel, input logic een, input logic erdy);
    return row(rdy, tr, wr, a, wd, rd, esel, een, erdy, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (row %0d): got %h expected %h", name, rowno, act, exp);
    end
  endtask

  // One bus cycle: drive at negedge, sample 1ns after the following posedge.
  task automatic apply(input vec_t v);
    xfer_t x;
    @(negedge Hclk);
    Hreadyin = v.rdy; Htrans = v.tr; Hwrite = v.wr;
    Haddr = v.addr; Hwdata = v.wdata; Prdata = v.prdata;
    if (v.push) sbq.push_back('{v.x_sel, v.x_addr, v.x_data, v.x_wr});
    @(posedge Hclk);
    #1;
    chk("Pselx", {29'd0, Pselx}, {29'd0, v.e_sel});
    chk("Penable", {31'd0, Penable}, {31'd0, v.e_en});
    chk("Hreadyout", {31'd0, Hreadyout}, {31'd0, v.e_rdy});
    chk("Hresp", {30'd0, Hresp}, 32'd0);
    if (Penable === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_enable", 32'd1, 32'd0);
      end else begin
        x = sbq.pop_front();
        chk("sb_Pselx", {29'd0, Pselx}, {29'd0, x.sel});
        chk("sb_Paddr", Paddr, x.addr);
        chk("sb_Pwrite", {31'd0, Pwrite}, {31'd0, x.wr});
        if (x.wr) chk("sb_Pwdata", Pwdata, x.data);
        else      chk("sb_Hrdata", Hrdata, x.data);
      end
    end
    rowno++;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    // single write
    vecs.push_back(row(1, T_NSEQ, 1, 32'h8000_0000, 0, 0, 3'b000, 0, 1, 1, 3'b001, 32'h8000_0000, 32'hA5, 1));
    vecs.push_back(rw(1, T_IDLE, 1, 0, 32'hA5, 0, 3'b001, 0, 0));
    vecs.push_back(rw(1, T_IDLE, 1, 0, 0, 0, 3'b001, 1, 1));
    vecs.push_back(rw(1, T_IDLE, 1, 0, 0, 0, 3'b000, 0, 1));
    // single read
    vecs.push_back(row(1, T_NSEQ, 0, 32'h8400_0010, 0, 32'hDEAD_BEEF, 3'b010, 0, 0, 1, 3'b010, 32'h8400_0010, 32'h1234_5678, 0));
    vecs.push_back(rw(1, T_NSEQ, 0, 32'h8400_0010, 0, 32'h1234_5678, 3'b010, 1, 1));
    vecs.push_back(rw(1, T_IDLE, 0, 0, 0, 0, 3'b000, 0, 1));
    // 4-beat write burst: WRITEP/WENABLEP alternate with no IDLE between beats
    vecs.push_back(row(1, T_NSEQ, 1, BA, 0, 0, 3'b000, 0, 1, 1, 3'b100, BA, 1, 1));
    vecs.push_back(row(1, T_SEQ, 1, BA + 4, 1, 0, 3'b100, 0, 0, 1, 3'b100, BA + 4, 2, 1));
    vecs.push_back(row(1, T_SEQ, 1, BA + 8, 2, 0, 3'b100, 1, 1, 1, 3'b100, BA + 8, 3, 1));
    vecs.push_back(rw(1, T_SEQ, 1, BA + 8, 2, 0, 3'b100, 0, 0));
    vecs.push_back(row(1, T_SEQ, 1, BA + 12, 3, 0, 3'b100, 1, 1, 1, 3'b100, BA + 12, 4, 1));
    vecs.push_back(rw(1, T_SEQ, 1, BA + 12, 3, 0, 3'b100, 0, 0));
    vecs.push_back(rw(1, T_IDLE, 1, 0, 4, 0, 3'b100, 1, 1));
    vecs.push_back(rw(1, T_IDLE, 1, 0, 4, 0, 3'b100, 0, 0));
    vecs.push_back(rw(1, T_IDLE, 1, 0, 0, 0, 3'b100, 1, 1));
    vecs.push_back(rw(1, T_IDLE, 1, 0, 0, 0, 3'b000, 0, 1));
    // reads at the top edge of the third and first windows
    vecs.push_back(row(1, T_NSEQ, 0, 32'h8BFF_FFFC, 0, 0, 3'b100, 0, 0, 1, 3'b100, 32'h8BFF_FFFC, 32'hCAFE_0001, 0));
    vecs.push_back(rw(1, T_NSEQ, 0, 32'h8BFF_FFFC, 0, 32'hCAFE_0001, 3'b100, 1, 1));
    vecs.push_back(rw(1, T_IDLE, 0, 0, 0, 0, 3'b000, 0, 1));
    vecs.push_back(row(1, T_NSEQ, 0, 32'h83FF_FFFC, 0, 0, 3'b001, 0, 0, 1, 3'b001, 32'h83FF_FFFC, 32'h0BAD_F00D, 0));
    vecs.push_back(rw(1, T_NSEQ, 0, 32'h83FF_FFFC, 0, 32'h0BAD_F00D, 3'b001, 1, 1));
    vecs.push_back(rw(1, T_IDLE, 0, 0, 0, 0, 3'b000, 0, 1));
    // transfers that must not be accepted
    vecs.push_back(rw(1, T_NSEQ, 1, 32'h7000_0000, 0, 0, 3'b000, 0, 1));
    vecs.push_back(rw(1, T_NSEQ, 0, 32'h8C00_0000, 0, 0, 3'b000, 0, 1));
    vecs.push_back(rw(1, T_BUSY, 1, 32'h8000_0000, 0, 0, 3'b000, 0, 1));
    vecs.push_back(rw(0, T_NSEQ, 1, 32'h8000_0000, 0, 0, 3'b000, 0, 1));
    vecs.push_back(rw(0, T_SEQ, 0, 32'h8400_0000, 0, 0, 3'b000, 0, 1));
    vecs.push_back(rw(1, T_IDLE, 1, 0, 0, 0, 3'b000, 0, 1));

    // reset state
    repeat (2) @(posedge Hclk);
    #1;
    chk("rst_Pselx", {29'd0, Pselx}, 32'd0);
    chk("rst_Penable", {31'd0, Penable}, 32'd0);
    chk("rst_Hreadyout", {31'd0, Hreadyout}, 32'd1);
    chk("rst_Hresp", {30'd0, Hresp}, 32'd0);
    chk("rst_Paddr", Paddr, 32'd0);
    chk("rst_Pwdata", Pwdata, 32'd0);
    chk("rst_Pwrite", {31'd0, Pwrite}, 32'd0);
    @(negedge Hclk);
    Hresetn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // reset asserted during a write SETUP cycle, away from any clock edge
    apply(row(1, T_NSEQ, 1, 32'h8000_0000, 0, 0, 3'b000, 0, 1, 1, 3'b001, 32'h8000_0000, 32'h55, 1));
    apply(rw(1, T_IDLE, 1, 0, 32'h55, 0, 3'b001, 0, 0));
    #2;
    Hresetn = 1'b0;
    #1;
    chk("midrst_Pselx", {29'd0, Pselx}, 32'd0);
    chk("midrst_Penable", {31'd0, Penable}, 32'd0);
    chk("midrst_Hreadyout", {31'd0, Hreadyout}, 32'd1);
    chk("midrst_Paddr", Paddr, 32'd0);
    chk("midrst_Pwdata", Pwdata, 32'd0);
    sbq.delete();
    @(negedge Hclk);
    Hresetn = 1'b1;
    apply(row(1, T_NSEQ, 1, BA + 4, 0, 0, 3'b000, 0, 1, 1, 3'b100, BA + 4, 32'hC3, 1));
    apply(rw(1, T_IDLE, 1, 0, 32'hC3, 0, 3'b100, 0, 0));
    apply(rw(1, T_IDLE, 1, 0, 0, 0, 3'b100, 1, 1));
    apply(rw(1, T_IDLE, 1, 0, 0, 0, 3'b000, 0, 1));

    chk("sb_empty", sbq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
